// File: rtl/score_collector_if.sv
// Result stream between score_collector (master) and the host result path (slave).
// Handshake: a beat transfers when out_valid & out_ready; payload holds while valid and not ready.
interface score_collector_if #(
    parameter int ID_WIDTH    = 48,
    parameter int SCORE_WIDTH = 12
);
    logic                   out_valid;
    logic                   out_ready;
    logic [ID_WIDTH-1:0]    out_id;
    logic [SCORE_WIDTH-1:0] out_score;

    modport master (output out_valid, output out_id, output out_score, input out_ready);
    modport slave  (input out_valid, input out_id, input out_score, output out_ready);
endinterface

// File: rtl/score_collector.sv
// Collects new per-slot ScoreBank results, arbitrates them round-robin into a show-ahead
// FIFO and keeps a sorted top-K table. Optional threshold filter: SC_THRESHOLD_EN.
module score_collector #(
    parameter int SCORE_WIDTH = 12,
    parameter int ID_WIDTH    = 48,
    parameter int SLOTS       = 16,
    parameter int FIFO_DEPTH  = 16,
    parameter int TOP_K       = 4,
    parameter int ZERO        = 2048
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          query_start,
    input  logic                          query_end,
    input  logic [SLOTS*SCORE_WIDTH-1:0]  results,
    input  logic [SLOTS*ID_WIDTH-1:0]     IDs,
    input  logic [SLOTS-1:0]              vld,
`ifdef SC_THRESHOLD_EN
    input  logic signed [SCORE_WIDTH-1:0] threshold,
`endif
    score_collector_if.master             out_if,
    output logic [TOP_K*SCORE_WIDTH-1:0]  topk_scores,
    output logic [TOP_K*ID_WIDTH-1:0]     topk_ids,
    output logic [TOP_K-1:0]              topk_vld,
    output logic [15:0]                   drop_cnt,
    output logic                          flush_done,
    output logic [1:0]                    state_o
);
    localparam int IDX_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int KW    = (TOP_K > 1) ? $clog2(TOP_K) : 1;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FLUSH = 2'd2} state_t;
    state_t state_q;

    logic [SLOTS-1:0]              vld_q, pend_q, pend_d, new_res, below, elig;
    logic [ID_WIDTH-1:0]           id_q [SLOTS];
    logic [ID_WIDTH-1:0]           pid_q [SLOTS];
    logic signed [SCORE_WIDTH-1:0] psc_q [SLOTS];
    logic [ID_WIDTH-1:0]           slot_id [SLOTS];
    logic signed [SCORE_WIDTH-1:0] slot_sc [SLOTS];
    logic [IDX_W-1:0]              ptr_q, gnt_idx;
    logic                          gnt_vld, push, pop, flush_cond;
    logic [ID_WIDTH-1:0]           gnt_id;
    logic signed [SCORE_WIDTH-1:0] gnt_sc;
    logic [15:0]                   drop_q, drop_d;
    logic [16:0]                   drop_sum;

    logic [ID_WIDTH-1:0]           mem_id [FIFO_DEPTH];
    logic [SCORE_WIDTH-1:0]        mem_sc [FIFO_DEPTH];
    logic [AW:0]                   wr_q, rd_q;
    logic                          full, empty;

    logic signed [SCORE_WIDTH-1:0] tk_sc_q [TOP_K];
    logic signed [SCORE_WIDTH-1:0] tk_sc_d [TOP_K];
    logic [ID_WIDTH-1:0]           tk_id_q [TOP_K];
    logic [ID_WIDTH-1:0]           tk_id_d [TOP_K];
    logic [TOP_K-1:0]              tk_v_q, tk_v_d;
    logic                          ins_hit;
    logic [KW-1:0]                 ins_pos;

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);

    // A below-threshold grant never enters the FIFO, so it may proceed while full.
    always_comb begin
        for (int s = 0; s < SLOTS; s++) begin
            slot_id[s] = IDs[(SLOTS-1-s)*ID_WIDTH +: ID_WIDTH];
            slot_sc[s] = results[(SLOTS-1-s)*SCORE_WIDTH +: SCORE_WIDTH] - SCORE_WIDTH'(ZERO);
            new_res[s] = vld[s] && (!vld_q[s] || (slot_id[s] != id_q[s]));
`ifdef SC_THRESHOLD_EN
            below[s]   = (psc_q[s] < threshold);
`else
            below[s]   = 1'b0;
`endif
            elig[s]    = pend_q[s] && !query_start && (!full || below[s]);
        end
    end

    // Rotating priority: slots at or after ptr_q first, then the wrapped remainder.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int s = 0; s < SLOTS; s++) begin
            if (!gnt_vld && elig[s] && (s >= int'(ptr_q))) begin
                gnt_vld = 1'b1;
                gnt_idx = IDX_W'(s);
            end
        end
        for (int s = 0; s < SLOTS; s++) begin
            if (!gnt_vld && elig[s]) begin
                gnt_vld = 1'b1;
                gnt_idx = IDX_W'(s);
            end
        end
    end

    assign gnt_id = pid_q[gnt_idx];
    assign gnt_sc = psc_q[gnt_idx];
    assign push   = gnt_vld && !below[gnt_idx];
    assign pop    = !empty && out_if.out_ready;

    // A new result on the slot being granted re-arms pending without counting a drop.
    always_comb begin
        drop_sum = {1'b0, drop_q};
        for (int s = 0; s < SLOTS; s++) begin
            pend_d[s] = pend_q[s] && !query_start;
            if (gnt_vld && (int'(gnt_idx) == s)) pend_d[s] = 1'b0;
            else if (new_res[s] && pend_d[s]) drop_sum = drop_sum + 17'd1;
            if (new_res[s]) pend_d[s] = 1'b1;
        end
        drop_d = query_start ? 16'd0 : (drop_sum[16] ? 16'hFFFF : drop_sum[15:0]);
    end

    // Strict '>' keeps an existing equal score ahead of the newcomer.
    always_comb begin
        ins_hit = 1'b0;
        ins_pos = '0;
        for (int i = 0; i < TOP_K; i++) begin
            if (!ins_hit && (!tk_v_q[i] || (gnt_sc > tk_sc_q[i]))) begin
                ins_hit = 1'b1;
                ins_pos = KW'(i);
            end
        end
        tk_sc_d = tk_sc_q;
        tk_id_d = tk_id_q;
        tk_v_d  = tk_v_q;
        if (gnt_vld && ins_hit) begin
            for (int i = TOP_K-1; i > 0; i--) begin
                if (i > int'(ins_pos)) begin
                    tk_sc_d[i] = tk_sc_q[i-1];
                    tk_id_d[i] = tk_id_q[i-1];
                    tk_v_d[i]  = tk_v_q[i-1];
                end
            end
            tk_sc_d[ins_pos] = gnt_sc;
            tk_id_d[ins_pos] = gnt_id;
            tk_v_d[ins_pos]  = 1'b1;
        end
        if (query_start) begin
            tk_v_d = '0;
            for (int i = 0; i < TOP_K; i++) begin
                tk_sc_d[i] = '0;
                tk_id_d[i] = '0;
            end
        end
    end

    assign flush_cond = (state_q == S_FLUSH) && (pend_q == '0) && empty && (new_res == '0);
    assign flush_done = flush_cond && !query_start;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            vld_q   <= '0;
            pend_q  <= '0;
            ptr_q   <= '0;
            drop_q  <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            tk_v_q  <= '0;
            for (int s = 0; s < SLOTS; s++) begin
                id_q[s]  <= '0;
                pid_q[s] <= '0;
                psc_q[s] <= '0;
            end
            for (int i = 0; i < TOP_K; i++) begin
                tk_sc_q[i] <= '0;
                tk_id_q[i] <= '0;
            end
        end else begin
            vld_q  <= vld;
            pend_q <= pend_d;
            drop_q <= drop_d;
            tk_v_q <= tk_v_d;
            for (int s = 0; s < SLOTS; s++) begin
                id_q[s] <= slot_id[s];
                if (new_res[s]) begin
                    pid_q[s] <= slot_id[s];
                    psc_q[s] <= slot_sc[s];
                end
            end
            for (int i = 0; i < TOP_K; i++) begin
                tk_sc_q[i] <= tk_sc_d[i];
                tk_id_q[i] <= tk_id_d[i];
            end
            if (gnt_vld) ptr_q <= (int'(gnt_idx) == SLOTS-1) ? '0 : gnt_idx + 1'b1;
            if (push) wr_q <= wr_q + 1'b1;
            if (pop) rd_q <= rd_q + 1'b1;
            if (query_start) state_q <= S_RUN;
            else begin
                case (state_q)
                    S_RUN:   if (query_end) state_q <= S_FLUSH;
                    S_FLUSH: if (flush_cond) state_q <= S_IDLE;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_id[wr_q[AW-1:0]] <= gnt_id;
            mem_sc[wr_q[AW-1:0]] <= gnt_sc;
        end
    end

    assign out_if.out_valid = !empty;
    assign out_if.out_id    = empty ? '0 : mem_id[rd_q[AW-1:0]];
    assign out_if.out_score = empty ? '0 : mem_sc[rd_q[AW-1:0]];

    always_comb begin
        for (int i = 0; i < TOP_K; i++) begin
            topk_scores[(TOP_K-1-i)*SCORE_WIDTH +: SCORE_WIDTH] = tk_sc_q[i];
            topk_ids[(TOP_K-1-i)*ID_WIDTH +: ID_WIDTH]          = tk_id_q[i];
        end
    end

    assign topk_vld = tk_v_q;
    assign drop_cnt = drop_q;
    assign state_o  = state_q;
endmodule
